// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: FSM state encoding and default widths.
package mem_stage_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;
   localparam int REG_W_DEF  = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Request/acknowledge bus between the memory-access stage (master) and the data memory (slave).
interface mem_stage_if
   import mem_stage_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   logic              mem_req_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic              mem_ack_i;
   logic [DATA_W-1:0] mem_rdata_i;

   modport master (
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      input  mem_ack_i, mem_rdata_i
   );

   modport slave (
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      output mem_ack_i, mem_rdata_i
   );

endinterface

// File: rtl/mem_stage_mem_wb_reg.sv
// MEM/WB boundary register: captures the stage result, or a bubble that clears the control bits.
module mem_wb_reg
   import mem_stage_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_W  = REG_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              bubble_i,
   input  logic              RegWrite_i,
   input  logic              MemToReg_i,
   input  logic [DATA_W-1:0] ReadData_i,
   input  logic [ADDR_W-1:0] ALUResult_i,
   input  logic [REG_W-1:0]  WriteReg_i,
   output logic              RegWrite_o,
   output logic              MemToReg_o,
   output logic [DATA_W-1:0] ReadData_o,
   output logic [ADDR_W-1:0] ALUResult_o,
   output logic [REG_W-1:0]  WriteReg_o
);

   logic              r_reg_write;
   logic              r_mem_to_reg;
   logic [DATA_W-1:0] r_read_data;
   logic [ADDR_W-1:0] r_alu_result;
   logic [REG_W-1:0]  r_write_reg;

   // A bubble only kills the control bits; the data fields keep their last value.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_reg_write  <= 1'b0;
         r_mem_to_reg <= 1'b0;
         r_read_data  <= '0;
         r_alu_result <= '0;
         r_write_reg  <= '0;
      end else if (bubble_i) begin
         r_reg_write  <= 1'b0;
         r_mem_to_reg <= 1'b0;
      end else begin
         r_reg_write  <= RegWrite_i;
         r_mem_to_reg <= MemToReg_i;
         r_read_data  <= ReadData_i;
         r_alu_result <= ALUResult_i;
         r_write_reg  <= WriteReg_i;
      end
   end

   assign RegWrite_o  = r_reg_write;
   assign MemToReg_o  = r_mem_to_reg;
   assign ReadData_o  = r_read_data;
   assign ALUResult_o = r_alu_result;
   assign WriteReg_o  = r_write_reg;

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores over a req/ack bus and stalls upstream meanwhile.
// Optional macro MEM_ALIGN_CHECK_EN: misaligned accesses are dropped and flagged on misalign_o.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_W  = REG_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [ADDR_W-1:0] ALUResult_i,
   input  logic [DATA_W-1:0] WriteData_i,
   input  logic [REG_W-1:0]  WriteReg_i,
   input  logic              RegWrite_i,
   input  logic              MemToReg_i,
   input  logic              MemRead_i,
   input  logic              MemWrite_i,
   mem_stage_if.master       mem_bus,
   output logic              stall_o,
   output logic              RegWrite_o,
   output logic              MemToReg_o,
   output logic [DATA_W-1:0] ReadData_o,
   output logic [ADDR_W-1:0] ALUResult_o,
   output logic [REG_W-1:0]  WriteReg_o,
   output logic              misalign_o
);

   state_t            r_state;
   logic              r_mem_req;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [DATA_W-1:0] r_hold;

   logic              w_op;
   logic              w_misalign;
   logic              w_issue;
   logic              w_wb_bubble;
   logic              w_wb_reg_write;
   logic [DATA_W-1:0] w_wb_read_data;

   assign w_op = MemRead_i | MemWrite_i;

`ifdef MEM_ALIGN_CHECK_EN
   assign w_misalign = w_op && (ALUResult_i[1:0] != 2'b00);
`else
   assign w_misalign = 1'b0;
`endif

   assign w_issue        = w_op && !w_misalign;
   assign w_wb_reg_write = RegWrite_i & ~w_misalign;

   always_comb begin
      stall_o        = 1'b0;
      w_wb_bubble    = 1'b1;
      w_wb_read_data = '0;
      case (r_state)
         IDLE: begin
            stall_o     = w_issue;
            w_wb_bubble = w_issue;
         end
         WAIT: stall_o = 1'b1;
         DONE: begin
            w_wb_bubble    = 1'b0;
            w_wb_read_data = r_hold;
         end
         default: ;
      endcase
      // Reset abandons any access, so upstream must not stay frozen while it is held.
      if (rst_i) stall_o = 1'b0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= IDLE;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_hold      <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_issue) begin
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= MemWrite_i;
                  r_mem_addr  <= ALUResult_i;
                  r_mem_wdata <= WriteData_i;
                  r_state     <= WAIT;
               end
            end
            WAIT: begin
               if (mem_bus.mem_ack_i) begin
                  r_hold    <= r_mem_we ? '0 : mem_bus.mem_rdata_i;
                  r_mem_req <= 1'b0;
                  r_state   <= DONE;
               end
            end
            // Upstream was frozen, so the op still on the inputs retires here without reissue.
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef MEM_ALIGN_CHECK_EN
   logic r_misalign;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_misalign <= 1'b0;
      end else begin
         r_misalign <= (r_state == IDLE) && w_misalign;
      end
   end

   assign misalign_o = r_misalign;
`else
   assign misalign_o = 1'b0;
`endif

   assign mem_bus.mem_req_o   = r_mem_req;
   assign mem_bus.mem_we_o    = r_mem_we;
   assign mem_bus.mem_addr_o  = r_mem_addr;
   assign mem_bus.mem_wdata_o = r_mem_wdata;

   mem_wb_reg #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .REG_W  (REG_W)
   ) u_mem_wb (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .bubble_i    (w_wb_bubble),
      .RegWrite_i  (w_wb_reg_write),
      .MemToReg_i  (MemToReg_i),
      .ReadData_i  (w_wb_read_data),
      .ALUResult_i (ALUResult_i),
      .WriteReg_i  (WriteReg_i),
      .RegWrite_o  (RegWrite_o),
      .MemToReg_o  (MemToReg_o),
      .ReadData_o  (ReadData_o),
      .ALUResult_o (ALUResult_o),
      .WriteReg_o  (WriteReg_o)
   );

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: random ops, a behavioural memory slave and a MEM/WB monitor.
module tb_mem_stage;

   typedef struct {
      logic        rw;
      logic        m2r;
      logic [31:0] rd;
      logic [31:0] alu;
      logic [4:0]  wr;
      logic        mis;
   } wb_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          delay;
   } req_t;

   logic        clk;
   logic        rst;
   logic [31:0] ALUResult;
   logic [31:0] WriteData;
   logic [4:0]  WriteReg;
   logic        RegWrite, MemToReg, MemRead, MemWrite;
   logic        stall_o, RegWrite_o, MemToReg_o, misalign_o;
   logic [31:0] ReadData_o, ALUResult_o;
   logic [4:0]  WriteReg_o;

   mem_stage_if bus ();

   mem_stage dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .ALUResult_i (ALUResult),
      .WriteData_i (WriteData),
      .WriteReg_i  (WriteReg),
      .RegWrite_i  (RegWrite),
      .MemToReg_i  (MemToReg),
      .MemRead_i   (MemRead),
      .MemWrite_i  (MemWrite),
      .mem_bus     (bus),
      .stall_o     (stall_o),
      .RegWrite_o  (RegWrite_o),
      .MemToReg_o  (MemToReg_o),
      .ReadData_o  (ReadData_o),
      .ALUResult_o (ALUResult_o),
      .WriteReg_o  (WriteReg_o),
      .misalign_o  (misalign_o)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   wb_t         wb_q[$];
   req_t        rq[$];
   logic [31:0] ref_mem[256];
   logic [31:0] slave_mem[256];
   logic        slave_en    = 1'b1;
   logic        manual_ack  = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
      end
   endtask

   // Behavioural data memory: acks each request after its scheduled delay, injects stray acks when idle.
   logic  s_busy = 1'b0;
   int    s_cnt;
   req_t  s_cur;
   req_t  s_exp;
   logic  s_ack;
   initial begin
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = '0;
      forever begin
         @(negedge clk);
         s_ack = 1'b0;
         if (slave_en && bus.mem_req_o) begin
            if (!s_busy) begin
               s_busy      = 1'b1;
               s_cnt       = 0;
               s_cur.we    = bus.mem_we_o;
               s_cur.addr  = bus.mem_addr_o;
               s_cur.wdata = bus.mem_wdata_o;
               if (rq.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL req_unexpected: got request addr 0x%0h required none", s_cur.addr);
                  s_cur.delay = 1;
               end else begin
                  s_exp = rq.pop_front();
                  check("req_we", {63'd0, s_cur.we}, {63'd0, s_exp.we});
                  check("req_addr", {32'd0, s_cur.addr}, {32'd0, s_exp.addr});
                  if (s_exp.we) check("req_wdata", {32'd0, s_cur.wdata}, {32'd0, s_exp.wdata});
                  s_cur.delay = s_exp.delay;
               end
               $display("REQ we=%0d addr=0x%08h wdata=0x%08h delay=%0d",
                        s_cur.we, s_cur.addr, s_cur.wdata, s_cur.delay);
            end else begin
               check("req_stable", {bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o[30:0]},
                     {s_cur.we, s_cur.addr, s_cur.wdata[30:0]});
            end
            s_cnt++;
            if (s_cnt == s_cur.delay) begin
               s_ack = 1'b1;
               if (s_cur.we) begin
                  slave_mem[s_cur.addr[9:2]] = s_cur.wdata;
                  bus.mem_rdata_i = $urandom;
               end else begin
                  bus.mem_rdata_i = slave_mem[s_cur.addr[9:2]];
               end
            end else begin
               bus.mem_rdata_i = $urandom;
            end
         end else begin
            s_busy = 1'b0;
            s_ack  = slave_en && ($urandom_range(0, 1) == 1);
            bus.mem_rdata_i = $urandom;
         end
         bus.mem_ack_i = s_ack | manual_ack;
      end
   end

   // MEM/WB monitor: every visible retirement is popped from the scoreboard.
   initial begin
      wb_t e;
      forever begin
         @(negedge clk);
         if (!rst && (RegWrite_o || misalign_o)) begin
            $display("WB  rw=%0d m2r=%0d rd=0x%08h alu=0x%08h wr=%0d mis=%0d",
                     RegWrite_o, MemToReg_o, ReadData_o, ALUResult_o, WriteReg_o, misalign_o);
            if (wb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL wb_unexpected: got retirement alu 0x%0h required none", ALUResult_o);
            end else begin
               e = wb_q.pop_front();
               check("wb_regwrite", {63'd0, RegWrite_o}, {63'd0, e.rw});
               check("wb_memtoreg", {63'd0, MemToReg_o}, {63'd0, e.m2r});
               check("wb_readdata", {32'd0, ReadData_o}, {32'd0, e.rd});
               check("wb_aluresult", {32'd0, ALUResult_o}, {32'd0, e.alu});
               check("wb_writereg", {59'd0, WriteReg_o}, {59'd0, e.wr});
               check("wb_misalign", {63'd0, misalign_o}, {63'd0, e.mis});
            end
         end
      end
   end

   task automatic set_nop();
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
      MemToReg  = 1'b0;
      ALUResult = '0;
      WriteData = '0;
      WriteReg  = '0;
   endtask

   // Presents one instruction, holds it while stalled, and checks the stall length.
   task automatic do_op(input logic rd, input logic wr, input logic rw, input logic m2r,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] wreg, input int delay);
      wb_t  e;
      req_t r;
      logic op;
      logic mis;
      int   exp_stall;
      int   cnt;
      MemRead   = rd;
      MemWrite  = wr;
      RegWrite  = rw;
      MemToReg  = m2r;
      ALUResult = addr;
      WriteData = wdata;
      WriteReg  = wreg;
      op  = rd | wr;
      mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      if (op && addr[1:0] != 2'b00) mis = 1'b1;
`endif
      e.m2r = m2r;
      e.alu = addr;
      e.wr  = wreg;
      e.mis = mis;
      e.rd  = '0;
      if (mis) begin
         e.rw      = 1'b0;
         exp_stall = 0;
      end else if (op) begin
         r.we    = wr;
         r.addr  = addr;
         r.wdata = wdata;
         r.delay = delay;
         rq.push_back(r);
         e.rw      = rw;
         exp_stall = delay + 1;
         if (wr) ref_mem[addr[9:2]] = wdata;
         else    e.rd = ref_mem[addr[9:2]];
      end else begin
         e.rw      = rw;
         exp_stall = 0;
      end
      if (e.rw || e.mis) wb_q.push_back(e);
      cnt = 0;
      for (int g = 0; g < 40; g++) begin
         @(negedge clk);
         if (!stall_o) break;
         cnt++;
      end
      check("stall_cycles", 64'(cnt), 64'(exp_stall));
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] v;
      int          k;
      logic [31:0] a;
      for (int i = 0; i < 256; i++) begin
         v = $urandom;
         ref_mem[i]   = v;
         slave_mem[i] = v;
      end
      ref_mem[64]   = 32'hDEADBEEF;
      slave_mem[64] = 32'hDEADBEEF;
      ref_mem[65]   = 32'hCAFEF00D;
      slave_mem[65] = 32'hCAFEF00D;

      rst = 1'b1;
      set_nop();
      #12;
      check("rst_req", {63'd0, bus.mem_req_o}, 64'd0);
      check("rst_stall", {63'd0, stall_o}, 64'd0);
      check("rst_regwrite", {63'd0, RegWrite_o}, 64'd0);
      check("rst_readdata", {32'd0, ReadData_o}, 64'd0);
      check("rst_aluresult", {32'd0, ALUResult_o}, 64'd0);
      check("rst_misalign", {63'd0, misalign_o}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      do_op(1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 5'd3, 1);
      do_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 5'd4, 1);
      do_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h12345678, 5'd0, 4);
      do_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 5'd5, 2);
      do_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h104, 32'h0, 5'd6, 1);
      do_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h102, 32'h0, 5'd7, 1);
      do_op(1'b0, 1'b0, 1'b1, 1'b0, 32'h55, 32'h0, 5'd8, 1);

      // Reset in the middle of an outstanding load.
      slave_en  = 1'b0;
      MemRead   = 1'b1;
      RegWrite  = 1'b1;
      MemToReg  = 1'b1;
      ALUResult = 32'h300;
      WriteReg  = 5'd9;
      @(negedge clk);
      check("mid_idle_stall", {63'd0, stall_o}, 64'd1);
      @(negedge clk);
      check("mid_wait_req", {63'd0, bus.mem_req_o}, 64'd1);
      #1 rst = 1'b1;
      #1;
      check("mid_rst_req", {63'd0, bus.mem_req_o}, 64'd0);
      check("mid_rst_stall", {63'd0, stall_o}, 64'd0);
      @(posedge clk);
      #1 set_nop();
      @(negedge clk);
      rst        = 1'b0;
      manual_ack = 1'b1;
      repeat (3) @(negedge clk);
      manual_ack = 1'b0;
      check("post_rst_req", {63'd0, bus.mem_req_o}, 64'd0);
      check("post_rst_stall", {63'd0, stall_o}, 64'd0);
      slave_en = 1'b1;
      @(posedge clk);
      #1;
      do_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h104, 32'h0, 5'd10, 3);

      for (int n = 0; n < 40; n++) begin
         k = $urandom_range(0, 3);
         a = 32'h100 + {22'd0, 6'($urandom_range(0, 63)), 2'b00};
         if ($urandom_range(0, 5) == 0) a = a + 32'($urandom_range(1, 3));
         case (k)
            0: do_op(1'b0, 1'b0, 1'b1, 1'b0, $urandom, 32'h0, 5'($urandom_range(1, 31)), 1);
            1: do_op(1'b1, 1'b0, 1'b1, 1'b1, a, 32'h0, 5'($urandom_range(1, 31)),
                     $urandom_range(1, 4));
            2: do_op(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, a, $urandom,
                     5'($urandom_range(1, 31)), $urandom_range(1, 4));
            default: do_op(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0, a, $urandom,
                           5'($urandom_range(1, 31)), $urandom_range(1, 4));
         endcase
      end

      set_nop();
      repeat (5) @(negedge clk);
      check("wb_queue_empty", 64'(wb_q.size()), 64'd0);
      check("req_queue_empty", 64'(rq.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the EX/MEM pipeline register. It consumes the ALU result, store data, write-register index and control bits.
- It performs data-memory loads and stores over a req/ack handshake to a multi-cycle data memory.
- It stalls the upstream pipeline while an access is outstanding.
- It registers the results into the MEM/WB boundary for the write-back stage.

Parameters:
- ADDR_W, 32, data memory address width (taken from ALUResult_i)
- DATA_W, 32, data word width
- REG_W, 5, register-file index width

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset, asynchronous, active-high
- ALUResult_i  in  ADDR_W  ALU result; this is the access address for loads and stores
- WriteData_i  in  DATA_W  store data
- WriteReg_i  in  REG_W  destination register index
- RegWrite_i  in  1  instruction writes the register file
- MemToReg_i  in  1  write-back selects memory data
- MemRead_i  in  1  load
- MemWrite_i  in  1  store
- mem_req_o  out  1  memory request, held until acknowledged
- mem_we_o  out  1  1 = write, 0 = read; valid while mem_req_o is high
- mem_addr_o  out  ADDR_W  request address
- mem_wdata_o  out  DATA_W  request write data
- mem_ack_i  in  1  memory done; sampled only while mem_req_o is high
- mem_rdata_i  in  DATA_W  read data; valid in the mem_ack_i cycle
- stall_o  out  1  freeze the PC, IF/ID, ID/EX and EX/MEM registers
- RegWrite_o  out  1  MEM/WB register-write enable
- MemToReg_o  out  1  MEM/WB write-back select
- ReadData_o  out  DATA_W  MEM/WB load data
- ALUResult_o  out  ADDR_W  MEM/WB ALU result
- WriteReg_o  out  REG_W  MEM/WB destination register
- misalign_o  out  1  registered misaligned-access flag (see Optional Feature)

Behaviour:
- Reset: asynchronous, active-high.
  - State goes to IDLE.
  - All registered outputs (mem_*_o, MEM/WB outputs, misalign_o) and the read-data hold register clear to 0.
  - stall_o is 0 in IDLE when no access is present.
  - Reset mid-access abandons the request: mem_req_o drops immediately and a later ack is ignored.
- Access op = MemRead_i | MemWrite_i. If both are high, it is treated as a store.
- State IDLE:
  - No access op: stall_o = 0; at the clock edge MEM/WB captures the inputs (pass-through, 1-cycle latency; ReadData_o <= 0).
  - Access op present: stall_o = 1 combinationally. At the clock edge:
    - mem_req_o <= 1;
    - mem_we_o <= MemWrite_i;
    - mem_addr_o <= ALUResult_i;
    - mem_wdata_o <= WriteData_i;
    - state -> WAIT;
    - MEM/WB captures a bubble (RegWrite_o = 0, MemToReg_o = 0).
- State WAIT:
  - stall_o = 1; mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o held stable.
  - MEM/WB captures a bubble each cycle.
  - On an edge with mem_ack_i = 1: hold register <= mem_rdata_i (loads only; stores load 0), mem_req_o <= 0, state -> DONE.
- State DONE:
  - stall_o = 0; the same op is still on the inputs (upstream was frozen) and is not re-issued.
  - At the clock edge: MEM/WB captures the inputs with ReadData_o <= hold register; state -> IDLE.
- Latency:
  - Non-memory ops: 1 cycle.
  - Memory ops: 3 cycles minimum (ack in the first request cycle), plus 1 cycle for each additional ack wait.
- mem_ack_i while mem_req_o = 0: ignored.
- Back-to-back accesses: the IDLE after DONE sees the next instruction and re-enters WAIT with no extra gap.
- The MEM/WB outputs hold their value only through bubbles; there is no separate enable.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN
- Defined:
  - An access op in IDLE with ALUResult_i[1:0] != 0 issues no request and raises no stall.
  - MEM/WB captures the inputs with RegWrite_o forced to 0, and misalign_o <= 1 for exactly that one cycle.
- Undefined:
  - No alignment check; the full address is sent to memory.
  - misalign_o is tied to 0.

Decomposition:
- Shared package/header:
  - state encoding (IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2);
  - default widths (ADDR_W, DATA_W, REG_W).
- Natural sub-module: mem_wb_reg, the MEM/WB capture register with a bubble input.
- The FSM and the request registers stay in mem_stage.

Test Plan:
- ALU op, RegWrite_i = 1, ALUResult_i = 0x00000010, WriteReg_i = 3 -> the next edge gives ALUResult_o = 0x10, WriteReg_o = 3, RegWrite_o = 1; stall_o never asserts.
- Load at 0x100, memory acks 1 cycle after req with rdata 0xDEADBEEF -> mem_req_o high for 1 cycle and stall_o high for 2 cycles; then RegWrite_o = 1, MemToReg_o = 1, ReadData_o = 0xDEADBEEF.
- Store of 0x12345678 to 0x200, ack delayed 4 cycles -> mem_we_o = 1, address and data stable for all 4 request cycles; stall_o high for 5 cycles; no RegWrite_o pulse; ReadData_o = 0.
- Back-to-back loads 0x100 then 0x104 -> exactly two requests with no duplicate request for 0x100; both results reach MEM/WB in order.
- rst_i asserted during WAIT -> mem_req_o = 0 and stall_o = 0 immediately; a later ack is ignored; the next op starts from IDLE.
- With MEM_ALIGN_CHECK_EN defined, load at 0x102 -> no mem_req_o, no stall, misalign_o = 1 for one cycle, RegWrite_o = 0.
